// File: rtl/gap_argmax.sv
`default_nettype none
// ============================================================================
// Module   : gap_argmax
// Brief    : Global-average-pool over a pixel-major channel stream followed by
//            a sequential argmax that reports the winning class and its score.
// Revision : 1.0  initial release
// ============================================================================
module gap_argmax #(
    parameter int DATA_W    = 16,
    parameter int CHANNELS  = 8,
    parameter int POOL_SIZE = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(CHANNELS)-1:0] class_idx,
    output logic [DATA_W-1:0]           class_score
);

    localparam int c_shift = $clog2(POOL_SIZE);
    localparam int c_acc_w = DATA_W + c_shift;
    localparam int c_ch_w  = $clog2(CHANNELS);

    localparam logic [c_ch_w-1:0]  c_last_ch = c_ch_w'(CHANNELS - 1);
    localparam logic [c_shift-1:0] c_last_px = c_shift'(POOL_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                     r_state;
    logic signed [c_acc_w-1:0]  r_acc [CHANNELS];
    logic [c_ch_w-1:0]          r_ch;
    logic [c_shift-1:0]         r_px;
    logic [c_ch_w-1:0]          r_k;
    logic [c_ch_w-1:0]          r_best_idx;
    logic signed [DATA_W-1:0]   r_best_score;

    logic                       w_beat;
    logic signed [c_acc_w-1:0]  w_sample;
    logic signed [DATA_W-1:0]   w_avg;
    logic                       w_take;
    logic [c_ch_w-1:0]          w_next_idx;
    logic signed [DATA_W-1:0]   w_next_score;

    assign in_ready = (r_state == S_ACCUM);
    assign busy     = (r_state == S_ACCUM) || (r_state == S_ARGMAX);
    assign w_beat   = in_valid && (r_state == S_ACCUM);

    // Sign-extend the incoming sample to accumulator width.
    assign w_sample = {{c_shift{in_data[DATA_W-1]}}, in_data};

    // Taking the upper DATA_W bits of the sum is an arithmetic shift right by
    // log2(POOL_SIZE), i.e. a floor average; the dropped top bits are pure
    // sign extension because the sum of POOL_SIZE samples always fits.
    assign w_avg = r_acc[r_k][c_acc_w-1:c_shift];

    // Channel 0 seeds the running best; later channels win only when strictly
    // greater, so ties settle on the lowest index.
    assign w_take       = (r_k == '0) || (w_avg > r_best_score);
    assign w_next_idx   = w_take ? r_k   : r_best_idx;
    assign w_next_score = w_take ? w_avg : r_best_score;

    // Frame control, accumulation, argmax scan and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ch         <= '0;
            r_px         <= '0;
            r_k          <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            done         <= 1'b0;
            class_idx    <= '0;
            class_score  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (start) begin
                // A new frame always wins, abandoning any frame in progress.
                r_state <= S_ACCUM;
                r_ch    <= '0;
                r_px    <= '0;
                r_k     <= '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_acc[i] <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_ACCUM: begin
                        if (w_beat) begin
                            r_acc[r_ch] <= r_acc[r_ch] + w_sample;
                            if (r_ch == c_last_ch) begin
                                r_ch <= '0;
                                r_px <= r_px + c_shift'(1);
                                if (r_px == c_last_px) begin
                                    r_state <= S_ARGMAX;
                                    r_k     <= '0;
                                end
                            end else begin
                                r_ch <= r_ch + c_ch_w'(1);
                            end
                        end
                    end
                    S_ARGMAX: begin
                        r_best_idx   <= w_next_idx;
                        r_best_score <= w_next_score;
                        if (r_k == c_last_ch) begin
                            class_idx   <= w_next_idx;
                            class_score <= w_next_score;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_k <= r_k + c_ch_w'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gap_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_gap_argmax
// Brief    : Scoreboard bench for gap_argmax (default parameters).
// Revision : 1.0  initial release
// ============================================================================
module tb_gap_argmax;

    localparam int DW = 16;
    localparam int CH = 8;
    localparam int PS = 64;
    localparam int CW = $clog2(CH);
    localparam int SH = $clog2(PS);
    localparam int FRAME = CH * PS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          busy;
    logic          done;
    logic [CW-1:0] class_idx;
    logic [DW-1:0] class_score;

    gap_argmax #(.DATA_W(DW), .CHANNELS(CH), .POOL_SIZE(PS)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .busy        (busy),
        .done        (done),
        .class_idx   (class_idx),
        .class_score (class_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int score;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   fr [PS][CH];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   done_count = 0;
    int   done_cyc   = 0;
    int   beat_cyc   = 0;
    logic prev_done  = 1'b0;

    always @(posedge clk) cyc++;

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
            checks++;
            if (prev_done === 1'b1) begin
                errors++;
                $display("FAIL done_pulse: done high for 2+ cycles, expected 1 cycle");
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got idx=%0d score=%0d, expected no done",
                         class_idx, $signed(class_score));
            end else begin
                mon_e = sb.pop_front();
                if (class_idx !== CW'(mon_e.idx) || class_score !== DW'(mon_e.score)) begin
                    errors++;
                    $display("FAIL result: got idx=%0d score=%0d, expected idx=%0d score=%0d",
                             class_idx, $signed(class_score), mon_e.idx, mon_e.score);
                end
            end
        end
        prev_done = done;
    end

    task automatic set_pattern(input int kind);
        for (int p = 0; p < PS; p++) begin
            for (int c = 0; c < CH; c++) begin
                case (kind)
                    0: fr[p][c] = c * 10;
                    1: fr[p][c] = 0;
                    2: fr[p][c] = (p == 0 && c == 5) ? 3 : 0;
                    3: fr[p][c] = (c == 3) ? -1 : -5;
                    4: fr[p][c] = (c == 2) ? ((p % 2 == 0) ? 1 : 2) : 0;
                    5: fr[p][c] = (c == 2) ? ((p % 2 == 0) ? -1 : -2) : -3;
                    6: fr[p][c] = (c == 6) ? 9 : 1;
                    7: fr[p][c] = (c == 0) ? 500 : 0;
                    default: fr[p][c] = (c == 4) ? 40 : c;
                endcase
            end
        end
    endtask

    // Reference model: floor-average each channel, strict-greater argmax.
    task automatic model_push();
        int   sums [CH];
        int   avg;
        exp_t e;
        for (int c = 0; c < CH; c++) sums[c] = 0;
        for (int p = 0; p < PS; p++)
            for (int c = 0; c < CH; c++) sums[c] += fr[p][c];
        e.idx   = 0;
        e.score = 0;
        for (int c = 0; c < CH; c++) begin
            avg = sums[c] >>> SH;
            if (c == 0 || avg > e.score) begin
                e.idx   = c;
                e.score = avg;
            end
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; leaves start high for exactly one rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_beats(input int n, input bit gaps);
        int i     = 0;
        int guard = 0;
        bit acc;
        while (i < n) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = DW'(fr[i / CH][i % CH]);
            acc      = in_valid && in_ready;
            if (acc && i == n - 1) beat_cyc = cyc;
            @(negedge clk);
            if (acc) i++;
            guard++;
            if (guard > 4 * n + 100) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: accepted %0d beats, expected %0d", i, n);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 200) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_after_frame: in_ready=%b, expected 0", in_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_count < target) begin
            errors++;
            $display("FAIL done_timeout: done count %0d, expected %0d", done_count, target);
        end
    endtask

    task automatic run_frame(input int kind, input bit gaps);
        int target;
        set_pattern(kind);
        model_push();
        target = done_count + 1;
        pulse_start();
        drive_beats(FRAME, gaps);
        wait_done(target);
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            class_idx !== '0 || class_score !== '0) begin
            errors++;
            $display("FAIL %s: ready=%b busy=%b done=%b idx=%0d score=%0d, expected all 0",
                     tag, in_ready, busy, done, class_idx, class_score);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset_release");
    endtask

    task automatic test_ramp();
        run_frame(0, 1'b0);
        checks++;
        if (done_cyc - beat_cyc != CH + 1) begin
            errors++;
            $display("FAIL done_latency: got %0d cycles, expected %0d", done_cyc - beat_cyc, CH + 1);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (class_idx !== CW'(7) || class_score !== DW'(70) || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL result_hold: idx=%0d score=%0d busy=%b done=%b, expected 7 70 0 0",
                     class_idx, class_score, busy, done);
        end
    endtask

    task automatic test_ties();
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
    endtask

    task automatic test_signed();
        run_frame(3, 1'b0);
        run_frame(4, 1'b0);
        run_frame(5, 1'b0);
    endtask

    task automatic test_gaps();
        // Beats offered while idle must be ignored.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(1000);
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready: ready=%b busy=%b, expected 0 0", in_ready, busy);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        run_frame(0, 1'b1);
    endtask

    task automatic test_abort();
        int n0;
        set_pattern(7);
        pulse_start();
        drive_beats(100, 1'b0);
        n0 = done_count;
        run_frame(6, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (done_count != n0 + 1 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_done_count: got %0d dones, expected %0d", done_count - n0, 1);
        end
    endtask

    task automatic test_start_wins();
        int target;
        set_pattern(7);
        pulse_start();
        drive_beats(FRAME - 1, 1'b0);
        set_pattern(6);
        model_push();
        target   = done_count + 1;
        in_valid = 1'b1;
        in_data  = '0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        drive_beats(FRAME, 1'b0);
        wait_done(target);
        repeat (12) @(negedge clk);
        checks++;
        if (done_count != target) begin
            errors++;
            $display("FAIL start_wins_count: got %0d dones, expected %0d", done_count, target);
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        set_pattern(0);
        pulse_start();
        drive_beats(200, 1'b0);
        n0 = done_count;
        #2 rst = 1'b1;
        #1 check_zero_outputs("reset_mid_accum");
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        drive_beats(FRAME, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL argmax_busy: busy=%b ready=%b, expected 1 0", busy, in_ready);
        end
        #2 rst = 1'b1;
        #1 check_zero_outputs("reset_mid_argmax");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (done_count != n0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d dones, expected 0", done_count - n0);
        end
        run_frame(8, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        test_reset();
        test_ramp();
        test_ties();
        test_signed();
        test_gaps();
        test_abort();
        test_start_wins();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gap_argmax.md
# gap_argmax

Parametrised global-average-pool and classifier stage that closes the final conv layer chain. It takes the last convolution layer's output feature maps as a pixel-major stream of signed words. It accumulates each channel over the full spatial extent and floor-averages each sum with an arithmetic shift. It then scans the channel averages sequentially and reports the winning class index and its score with a one-cycle `done` pulse. It generalises the fixed 8-channel, 64-pixel pool stage: channel count, pool size and data width are parameters, and the block adds frame control, input flow control and argmax.

## Interface
- `DATA_W`, 16: width of input samples and output score, signed two's complement.
- `CHANNELS`, 8: number of channels (classes); must be ≥2.
- `POOL_SIZE`, 64: pixels per channel per frame; must be a power of two, ≥2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  DATA_W  signed sample.
- `busy`  out  1  high in ACCUM and ARGMAX.
- `done`  out  1  one-cycle pulse when the result is valid.
- `class_idx`  out  $clog2(CHANNELS)  winning channel.
- `class_score`  out  DATA_W  floor-average of the winning channel.

## Operation
- Stream order is pixel-major: pixel 0 channels 0..CHANNELS-1, then pixel 1, and so on. Each frame is CHANNELS×POOL_SIZE beats.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 only in ACCUM. Beats while `in_ready` = 0 are dropped.
- Accumulators: CHANNELS registers, each signed DATA_W+log2(POOL_SIZE) bits, so overflow is impossible.
- Counters:
  - channel counter `ch` wraps at CHANNELS-1 and increments the pixel counter `px` on wrap;
  - on the last beat (`ch`=CHANNELS-1, `px`=POOL_SIZE-1) the FSM moves to ARGMAX.
- Average = `acc >>> log2(POOL_SIZE)`, i.e. floor toward −∞, truncated to DATA_W. The truncation is lossless by construction.
- State machine:
  - IDLE: no activity. `start` → ACCUM, clearing all accumulators and both counters.
  - ACCUM: accumulate accepted beats. The last beat → ARGMAX.
  - ARGMAX: scans k = 0..CHANNELS-1, one channel per cycle. Channel 0 seeds best index/score. Channel k replaces the best only if its average is strictly greater, so ties go to the lowest index. After k = CHANNELS-1 → DONE.
  - DONE: one cycle. `done` = 1, `class_idx`/`class_score` are loaded from best. → IDLE.
- `start` is honoured in every state. It aborts any frame in progress, clears accumulators and counters, and enters ACCUM; no `done` is produced for the aborted frame. If `start` arrives in the same cycle as the last accepted beat, `start` wins.
- `class_idx`/`class_score` hold their value until the next DONE or reset.

## Timing
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `class_idx`=0, `class_score`=0. State is IDLE, accumulators and counters are 0.
- `start` sampled at edge t: state is ACCUM and `in_ready`=1 from t+1.
- ARGMAX: last beat accepted at edge T. ARGMAX occupies cycles T+1..T+CHANNELS, and `done` is high in cycle T+CHANNELS+1. Defaults: 9 cycles after the last beat.
- Minimum frame-to-`done` time = CHANNELS×POOL_SIZE+CHANNELS+1 cycles from the first ACCUM cycle, with `in_valid` held high.
- `in_valid` gaps only stretch ACCUM; the result is unchanged.
- Asserting `rst` mid-frame returns all outputs to their reset values immediately (asynchronous). No `done` follows until a new `start`.

## Test plan
- Defaults; channel c is c×10 at every pixel, `in_valid` held high → `class_idx`=7, `class_score`=70; `done` exactly 9 cycles after the last beat, single cycle.
- All samples 0 → `class_idx`=0, `class_score`=0 (tie resolves to the lowest index). Then a channel 5 value of 3 in pixel 0 only (sum 3, avg 0) → still class 0.
- Channel 3 = −1 everywhere, others −5 → class 3, score −1. Channel 2 alternating 1/2 with others 0 → class 2, score 1. Channel 2 alternating −1/−2, others −3 → class 2, score −2 (floor).
- Random `in_valid` gaps (~50%) on the first test's stream → identical result; `in_ready` low outside ACCUM, and beats presented in IDLE are ignored.
- `start` pulsed after 100 beats, then a full new frame → exactly one `done`, and its result matches the new frame only.
- `rst` asserted mid-ACCUM and mid-ARGMAX → outputs 0 in the same cycle, no `done`; the next full frame then produces a correct result.
